csr_counter_ctrl: RTL and testbench
===================================

// Module: csr_counter_ctrl
// PURPOSE
//  Owns the 64-bit cycle/instret counters and sequences every Zicsr access to them.
//  It decodes the CSR address, runs a read/modify/write FSM under a req/ack handshake,
//  and applies increment, inhibit and write priority. It sits beside the EX stage and
//  replaces the free-standing counter read path. The pipeline holds its instruction
//  in EX until csr_ack is seen.
// PARAMETERS
//  CNT_W       64  counter width; fixed split into LO[31:0] / HI[CNT_W-1:32]
//  CYC_RST     0   reset value of mcycle
//  INS_RST     0   reset value of minstret
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  csr_req       in   1   access request; held high until csr_ack is seen
//  csr_addr      in   12  CSR address (instr[31:20])
//  csr_op        in   2   00 READ, 01 RW, 10 RS, 11 RC
//  csr_wdata     in   32  rs1 value or zimm, zero-extended
//  retire_valid  in   1   one instruction retires this cycle
//  csr_ack       out  1   one-cycle pulse: access complete
//  csr_rdata     out  32  old CSR value; valid only while csr_ack=1
//  csr_illegal   out  1   qualifies csr_ack: bad address or write to a read-only CSR
//  cycle_o       out  64  live mcycle (for debug/trace)
//  instret_o     out  64  live minstret
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; csr_ack=0, csr_rdata=0, csr_illegal=0.
//   - mcycle=CYC_RST, minstret=INS_RST, mcountinhibit=0.
//  Address map:
//   - mcycle B00, minstret B02, mcycleh B80, minstreth B82, mcountinhibit 320 (bits 0,2 live, rest read 0).
//   - cycle C00, instret C02, cycleh C80, instreth C82: read-only aliases.
//   - Any other address is illegal.
//  Write intent: op!=READ. RS/RC with wdata==0 still counts as a write (decoder already maps rs1=x0 to READ).
//  FSM:
//   - IDLE: on csr_req, latch addr/op/wdata -> RD.
//   - RD: capture the old value of the selected half into rd_q; flag illegal.
//     Next state is WR if write intent and legal, else DONE.
//   - WR: new=RW?wd : RS?rd_q|wd : rd_q&~wd. Write it into the selected half; other half untouched -> DONE.
//   - DONE: csr_ack=1, csr_rdata=rd_q (0 if illegal), csr_illegal as flagged -> IDLE.
//   - Latency req->ack: READ 3 clk, write 4 clk. Illegal access: no state change, 3 clk.
//  Counters:
//   - mcycle += 1 every clk unless mcountinhibit[0].
//   - minstret += 1 on retire_valid unless mcountinhibit[2].
//   - Full 64-bit increment; LO carry propagates into HI.
//   - 0xFFFF_FFFF_FFFF_FFFF wraps to 0 silently.
//  Priority and boundaries:
//   - WR write and increment in the same clk: the write wins for the whole counter (no increment that clk).
//     The next clk increments from the written value.
//   - RS/RC modify the RD-captured value, not the live one. The increment between RD and WR is intentionally lost.
//   - Writing mcountinhibit takes effect the clk after WR.
//   - csr_req is ignored outside IDLE. The requester deasserts req the clk ack is seen, so IDLE never re-triggers.
//   - retire_valid is counted in every state, including for the CSR instruction's own retire.
//   - rst_n low in any state aborts immediately. No ack is issued and no partial write persists.
// STRUCTURE
//  - csr_pkg: csr_op_e, ctrl_state_e {IDLE,RD,WR,DONE}, localparams for the 9 CSR addresses.
//  - Sub-module csr_counter64, instantiated twice: inc_en, wr_lo, wr_hi, wdata[31:0] -> q[63:0].
//    Write beats increment inside it.
// TESTING
//  - Reset then 10 free clk; READ C00 -> ack at req+3, rdata = cycle value at RD.
//    Value is 11 if sampled on the clk after 10 free clk.
//  - RW B00=0xFFFF_FFFF, B80=0 -> cycle_o steps 0x0_FFFFFFFF -> 0x1_00000000 (carry).
//  - RS 320 wdata=0x5, then 20 clk with retire_valid=1 -> cycle_o and instret_o frozen.
//    RC 320 wdata=0x5 -> counting resumes the clk after WR.
//  - RW C02 -> ack with csr_illegal=1, rdata=0, instret unchanged.
//    READ 7C0 -> illegal, 3-clk latency.
//  - retire_valid=1 during WR of minstret=0x10 -> instret_o=0x10 after WR, 0x11 next clk.
//  - rst_n low while in WR of mcycleh=0xAB -> cycle_o=0, no csr_ack, FSM in IDLE.
//    Then repeat the write -> succeeds normally.

Source files
------------

// File: rtl/csr_counter_ctrl_pkg.sv
// Shared types, CSR address map and decode/modify helpers for the counter CSR block.
package csr_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_CYC,
        TGT_INS,
        TGT_INH
    } csr_tgt_e;

    typedef struct packed {
        logic     legal;
        logic     ro;
        logic     hi;
        csr_tgt_e tgt;
    } csr_dec_t;

    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

    // Map a CSR address to its target counter/half and access rights.
    function automatic csr_dec_t csr_decode(input logic [11:0] addr);
        csr_dec_t d;
        d = '{legal: 1'b0, ro: 1'b0, hi: 1'b0, tgt: TGT_NONE};
        case (addr)
            ADDR_MCYCLE:        d = '{legal: 1'b1, ro: 1'b0, hi: 1'b0, tgt: TGT_CYC};
            ADDR_MCYCLEH:       d = '{legal: 1'b1, ro: 1'b0, hi: 1'b1, tgt: TGT_CYC};
            ADDR_MINSTRET:      d = '{legal: 1'b1, ro: 1'b0, hi: 1'b0, tgt: TGT_INS};
            ADDR_MINSTRETH:     d = '{legal: 1'b1, ro: 1'b0, hi: 1'b1, tgt: TGT_INS};
            ADDR_MCOUNTINHIBIT: d = '{legal: 1'b1, ro: 1'b0, hi: 1'b0, tgt: TGT_INH};
            ADDR_CYCLE:         d = '{legal: 1'b1, ro: 1'b1, hi: 1'b0, tgt: TGT_CYC};
            ADDR_CYCLEH:        d = '{legal: 1'b1, ro: 1'b1, hi: 1'b1, tgt: TGT_CYC};
            ADDR_INSTRET:       d = '{legal: 1'b1, ro: 1'b1, hi: 1'b0, tgt: TGT_INS};
            ADDR_INSTRETH:      d = '{legal: 1'b1, ro: 1'b1, hi: 1'b1, tgt: TGT_INS};
            default:            d = '{legal: 1'b0, ro: 1'b0, hi: 1'b0, tgt: TGT_NONE};
        endcase
        return d;
    endfunction

    // Zicsr read-modify-write of the value captured in RD.
    function automatic logic [31:0] csr_modify(input csr_op_e op, input logic [31:0] old,
                                               input logic [31:0] wd);
        logic [31:0] v;
        case (op)
            OP_RW:   v = wd;
            OP_RS:   v = old | wd;
            OP_RC:   v = old & ~wd;
            default: v = old;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csr_counter_ctrl_if.sv
// Zicsr request/acknowledge bus between the EX stage and the counter CSR block.
interface csr_counter_ctrl_if;

    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_req, csr_addr, csr_op, csr_wdata,
        input  csr_ack, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_req, csr_addr, csr_op, csr_wdata,
        output csr_ack, csr_rdata, csr_illegal
    );

endinterface

// File: rtl/csr_counter_ctrl_counter64.sv
// Wide free-running counter with per-half write port; a write beats the increment.
module csr_counter64 #(
    parameter int unsigned     W       = 64,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc_en,
    input  logic          i_wr_lo,
    input  logic          i_wr_hi,
    input  logic [31:0]   i_wdata,
    output logic [W-1:0]  o_q
);

    logic [W-1:0] r_q;

    // Counter register: write of either half suppresses that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_q[31:0]   <= i_wdata;
            if (i_wr_hi) r_q[W-1:32] <= i_wdata[W-33:0];
        end else if (i_inc_en) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/csr_counter_ctrl.sv
// mcycle/minstret owner: decodes Zicsr accesses and sequences them IDLE->RD->(WR)->DONE.
module csr_counter_ctrl
    import csr_counter_ctrl_pkg::*;
#(
    parameter int unsigned       CNT_W   = 64,
    parameter logic [CNT_W-1:0]  CYC_RST = '0,
    parameter logic [CNT_W-1:0]  INS_RST = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csr_counter_ctrl_if.slave    bus,
    input  logic                 retire_valid,
    output logic [CNT_W-1:0]     cycle_o,
    output logic [CNT_W-1:0]     instret_o
);

    ctrl_state_e  r_state;
    ctrl_state_e  w_next;
    logic [11:0]  r_addr;
    csr_op_e      r_op;
    logic [31:0]  r_wdata;
    logic [31:0]  r_rd_q;
    logic         r_illegal;
    logic         r_inh_cy;
    logic         r_inh_ir;

    csr_dec_t     w_dec;
    logic         w_wr_intent;
    logic         w_bad;
    logic [31:0]  w_cur;
    logic [31:0]  w_new;
    logic         w_we;
    logic         w_cyc_wr_lo;
    logic         w_cyc_wr_hi;
    logic         w_ins_wr_lo;
    logic         w_ins_wr_hi;

    assign w_dec       = csr_decode(r_addr);
    assign w_wr_intent = (r_op != OP_READ);
    assign w_bad       = !w_dec.legal || (w_wr_intent && w_dec.ro);
    assign w_new       = csr_modify(r_op, r_rd_q, r_wdata);
    assign w_we        = (r_state == ST_WR);
    assign w_cyc_wr_lo = w_we && (w_dec.tgt == TGT_CYC) && !w_dec.hi;
    assign w_cyc_wr_hi = w_we && (w_dec.tgt == TGT_CYC) &&  w_dec.hi;
    assign w_ins_wr_lo = w_we && (w_dec.tgt == TGT_INS) && !w_dec.hi;
    assign w_ins_wr_hi = w_we && (w_dec.tgt == TGT_INS) &&  w_dec.hi;

    // Current value of the addressed half, as seen during RD.
    always_comb begin
        w_cur = '0;
        case (w_dec.tgt)
            TGT_CYC: w_cur = w_dec.hi ? 32'(cycle_o[CNT_W-1:32])   : cycle_o[31:0];
            TGT_INS: w_cur = w_dec.hi ? 32'(instret_o[CNT_W-1:32]) : instret_o[31:0];
            TGT_INH: w_cur = {29'b0, r_inh_ir, 1'b0, r_inh_cy};
            default: w_cur = '0;
        endcase
    end

    // FSM state register; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and bus response outputs.
    always_comb begin
        w_next          = r_state;
        bus.csr_ack     = 1'b0;
        bus.csr_rdata   = '0;
        bus.csr_illegal = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.csr_req) w_next = ST_RD;
            ST_RD:   w_next = (w_wr_intent && !w_bad) ? ST_WR : ST_DONE;
            ST_WR:   w_next = ST_DONE;
            ST_DONE: begin
                w_next          = ST_IDLE;
                bus.csr_ack     = 1'b1;
                bus.csr_rdata   = r_illegal ? '0 : r_rd_q;
                bus.csr_illegal = r_illegal;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch in IDLE, old-value and legality capture in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_op      <= OP_READ;
            r_wdata   <= '0;
            r_rd_q    <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus.csr_req) begin
                r_addr  <= bus.csr_addr;
                r_op    <= csr_op_e'(bus.csr_op);
                r_wdata <= bus.csr_wdata;
            end
            if (r_state == ST_RD) begin
                r_rd_q    <= w_cur;
                r_illegal <= w_bad;
            end
        end
    end

    // mcountinhibit: only bits 0 and 2 are implemented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inh_cy <= 1'b0;
            r_inh_ir <= 1'b0;
        end else if (w_we && w_dec.tgt == TGT_INH) begin
            r_inh_cy <= w_new[0];
            r_inh_ir <= w_new[2];
        end
    end

    csr_counter64 #(
        .W       (CNT_W),
        .RST_VAL (CYC_RST)
    ) u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc_en (!r_inh_cy),
        .i_wr_lo  (w_cyc_wr_lo),
        .i_wr_hi  (w_cyc_wr_hi),
        .i_wdata  (w_new),
        .o_q      (cycle_o)
    );

    csr_counter64 #(
        .W       (CNT_W),
        .RST_VAL (INS_RST)
    ) u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc_en (retire_valid && !r_inh_ir),
        .i_wr_lo  (w_ins_wr_lo),
        .i_wr_hi  (w_ins_wr_hi),
        .i_wdata  (w_new),
        .o_q      (instret_o)
    );

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Directed bench for csr_counter_ctrl: hand sequences for timing corners plus a vector table.
module tb_csr_counter_ctrl;
    import csr_counter_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic [63:0] cycle_o;
    logic [63:0] instret_o;

    int unsigned checks;
    int unsigned errors;

    csr_counter_ctrl_if bus();

    csr_counter_ctrl #(
        .CNT_W   (64),
        .CYC_RST (64'h0),
        .INS_RST (64'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .retire_valid (retire_valid),
        .cycle_o      (cycle_o),
        .instret_o    (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_ill;
        int unsigned exp_lat;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Issue one access starting at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic do_csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic ill, output int unsigned lat,
                          output logic [63:0] ack_cyc, output logic [63:0] ack_ins);
        logic got;
        got     = 1'b0;
        rdata   = '0;
        ill     = 1'b0;
        lat     = 0;
        ack_cyc = '0;
        ack_ins = '0;
        bus.csr_req   = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        while (!got && lat < 16) begin
            @(negedge clk);
            lat++;
            if (bus.csr_ack) begin
                got     = 1'b1;
                rdata   = bus.csr_rdata;
                ill     = bus.csr_illegal;
                ack_cyc = cycle_o;
                ack_ins = instret_o;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none required=ack addr=0x%0h", addr);
        end
        @(posedge clk);
        #1;
        bus.csr_req = 1'b0;
    endtask

    logic [31:0]  rd;
    logic         il;
    int unsigned  lt;
    logic [63:0]  acyc;
    logic [63:0]  ains;

    initial begin
        checks = 0;
        errors = 0;

        tbl[0]  = '{2'b01, 12'h320, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0, 4};
        tbl[1]  = '{2'b01, 12'hB00, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 4};
        tbl[2]  = '{2'b01, 12'hB80, 32'h0000_CAFE, 1'b1, 32'h0000_00AB, 1'b0, 4};
        tbl[3]  = '{2'b00, 12'hC00, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0, 3};
        tbl[4]  = '{2'b00, 12'hC80, 32'h0000_0000, 1'b1, 32'h0000_CAFE, 1'b0, 3};
        tbl[5]  = '{2'b10, 12'hB00, 32'h0000_000F, 1'b1, 32'h1234_5678, 1'b0, 4};
        tbl[6]  = '{2'b00, 12'hB00, 32'h0000_0000, 1'b1, 32'h1234_567F, 1'b0, 3};
        tbl[7]  = '{2'b11, 12'hB00, 32'h0000_FF00, 1'b1, 32'h1234_567F, 1'b0, 4};
        tbl[8]  = '{2'b00, 12'hC00, 32'h0000_0000, 1'b1, 32'h1234_007F, 1'b0, 3};
        tbl[9]  = '{2'b01, 12'hB02, 32'hAAAA_5555, 1'b1, 32'h0000_0000, 1'b0, 4};
        tbl[10] = '{2'b01, 12'hB82, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 4};
        tbl[11] = '{2'b00, 12'hC82, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 3};
        tbl[12] = '{2'b00, 12'hC02, 32'h0000_0000, 1'b1, 32'hAAAA_5555, 1'b0, 3};
        tbl[13] = '{2'b10, 12'h320, 32'h0000_0000, 1'b1, 32'h0000_0005, 1'b0, 4};
        tbl[14] = '{2'b01, 12'hC80, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 3};
        tbl[15] = '{2'b00, 12'h7C0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 3};
        tbl[16] = '{2'b01, 12'h321, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 3};
        tbl[17] = '{2'b11, 12'h320, 32'h0000_0004, 1'b1, 32'h0000_0005, 1'b0, 4};
        tbl[18] = '{2'b00, 12'h320, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 3};

        rst_n         = 1'b0;
        retire_valid  = 1'b0;
        bus.csr_req   = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_op    = 2'b00;
        bus.csr_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",     {63'b0, bus.csr_ack},     64'h0);
        chk("rst_rdata",   {32'b0, bus.csr_rdata},   64'h0);
        chk("rst_illegal", {63'b0, bus.csr_illegal}, 64'h0);
        chk("rst_cycle",   cycle_o,   64'h0);
        chk("rst_instret", instret_o, 64'h0);

        // Ten free clocks, then READ cycle
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("free10_cycle", cycle_o, 64'd10);
        do_csr(2'b00, 12'hC00, 32'h0, rd, il, lt, acyc, ains);
        chk("rd_c00_rdata", {32'b0, rd}, 64'd11);
        chk("rd_c00_lat",   64'(lt),     64'd3);
        chk("rd_c00_ill",   {63'b0, il}, 64'h0);

        // Carry from LO into HI
        do_csr(2'b01, 12'hB80, 32'h0, rd, il, lt, acyc, ains);
        chk("wr_b80_rdata", {32'b0, rd}, 64'h0);
        chk("wr_b80_lat",   64'(lt),     64'd4);
        do_csr(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, il, lt, acyc, ains);
        chk("carry_at_ack", acyc,    64'h0_FFFF_FFFF);
        chk("carry_after",  cycle_o, 64'h1_0000_0000);

        // Inhibit both counters, then release
        do_csr(2'b10, 12'h320, 32'h5, rd, il, lt, acyc, ains);
        chk("inh_set_rdata", {32'b0, rd}, 64'h0);
        chk("inh_set_cycle", cycle_o, 64'h1_0000_0003);
        retire_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("inh_frozen_cycle",   cycle_o,   64'h1_0000_0003);
        chk("inh_frozen_instret", instret_o, 64'h0);
        do_csr(2'b11, 12'h320, 32'h5, rd, il, lt, acyc, ains);
        retire_valid = 1'b0;
        chk("inh_clr_rdata",   {32'b0, rd}, 64'h5);
        chk("inh_clr_ack_cyc", acyc,      64'h1_0000_0003);
        chk("inh_clr_cycle",   cycle_o,   64'h1_0000_0004);
        chk("inh_clr_instret", instret_o, 64'h1);

        // Illegal accesses
        do_csr(2'b01, 12'hC02, 32'h1234, rd, il, lt, acyc, ains);
        chk("ro_wr_ill",     {63'b0, il}, 64'h1);
        chk("ro_wr_rdata",   {32'b0, rd}, 64'h0);
        chk("ro_wr_lat",     64'(lt),     64'd3);
        chk("ro_wr_instret", instret_o,   64'h1);
        do_csr(2'b00, 12'h7C0, 32'h0, rd, il, lt, acyc, ains);
        chk("bad_addr_ill", {63'b0, il}, 64'h1);
        chk("bad_addr_lat", 64'(lt),     64'd3);

        // Retire during WR of minstret: write wins that clock
        retire_valid = 1'b1;
        do_csr(2'b01, 12'hB02, 32'h10, rd, il, lt, acyc, ains);
        retire_valid = 1'b0;
        chk("ret_wr_rdata",  {32'b0, rd}, 64'h2);
        chk("ret_wr_at_ack", ains,        64'h10);
        chk("ret_wr_after",  instret_o,   64'h11);

        // Reset while in WR of mcycleh
        bus.csr_req   = 1'b1;
        bus.csr_addr  = 12'hB80;
        bus.csr_op    = 2'b01;
        bus.csr_wdata = 32'hAB;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_in_wr", 64'(dut.r_state == ST_WR), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_cycle", cycle_o, 64'h0);
        chk("abort_idle",  64'(dut.r_state == ST_IDLE), 64'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_ack", {63'b0, bus.csr_ack}, 64'h0);
        bus.csr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_csr(2'b01, 12'hB80, 32'hAB, rd, il, lt, acyc, ains);
        chk("rewr_rdata", {32'b0, rd}, 64'h0);
        chk("rewr_lat",   64'(lt),     64'd4);
        chk("rewr_cycle", cycle_o,     64'hAB_0000_0004);

        // Vector table
        for (int i = 0; i < 19; i++) begin
            do_csr(tbl[i].op, tbl[i].addr, tbl[i].wd, rd, il, lt, acyc, ains);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), {32'b0, rd}, {32'b0, tbl[i].exp_rd});
            chk($sformatf("vec%0d_ill", i), {63'b0, il}, {63'b0, tbl[i].exp_ill});
            chk($sformatf("vec%0d_lat", i), 64'(lt), 64'(tbl[i].exp_lat));
        end
        chk("tbl_cycle",   cycle_o,   64'h0000_CAFE_1234_007F);
        chk("tbl_instret", instret_o, 64'h0000_0001_AAAA_5555);

        // Only cycle inhibited now: instret counts, cycle frozen
        retire_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        retire_valid = 1'b0;
        chk("part_inh_instret", instret_o, 64'h0000_0001_AAAA_555A);
        chk("part_inh_cycle",   cycle_o,   64'h0000_CAFE_1234_007F);

        // 64-bit wrap
        do_csr(2'b01, 12'hB82, 32'hFFFF_FFFF, rd, il, lt, acyc, ains);
        chk("wrap_hi_rdata", {32'b0, rd}, 64'h1);
        do_csr(2'b01, 12'hB02, 32'hFFFF_FFFF, rd, il, lt, acyc, ains);
        chk("wrap_lo_rdata", {32'b0, rd}, 64'hAAAA_555A);
        chk("wrap_full",     instret_o,   64'hFFFF_FFFF_FFFF_FFFF);
        retire_valid = 1'b1;
        @(posedge clk);
        #1;
        retire_valid = 1'b0;
        chk("wrap_zero", instret_o, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
